// File: rtl/pixel_link_pkg.sv
// Shared definitions for the FPGA-to-NANO pixel link: byte/pixel widths, the
// receive-side state encoding, and the byte-pair to pixel join.
package pixel_link_pkg;

    localparam int PIXEL_W     = 12;
    localparam int BYTE_W      = 8;
    localparam int HI_BYTE_MSB = 11;
    localparam int HI_BYTE_LSB = 4;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        PRESENT = 2'd2
    } rx_pixel_state_t;

    // High byte carries pixel[11:4]; the low byte carries pixel[3:0] in its upper nibble.
    function automatic logic [PIXEL_W-1:0] join_pixel(input logic [BYTE_W-1:0] hi,
                                                      input logic [BYTE_W-1:0] lo);
        return {hi, lo[BYTE_W-1:HI_BYTE_LSB]};
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: armed by start, disarmed by clear, and raises expired
// once TIMEOUT_CLKS-1 idle cycles have been counted since it was armed.
module byte_timeout #(
    parameter int TIMEOUT_CLKS = 13020
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] count;
    logic             active;

    assign expired = active && (count == LAST);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            count  <= '0;
            active <= 1'b1;
        end else if (active && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/receive_pixel.sv
// Reassembles hi/lo byte pairs from uart_rx into 12-bit pixels and presents
// them with a wrapping frame address on a valid/ready port.
module receive_pixel
    import pixel_link_pkg::*;
#(
    parameter int IMAGE_SIZE   = 4,
    parameter int ADDR_W       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
    parameter int TIMEOUT_CLKS = 13020
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_clear,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [11:0]       pixel_out,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              frame_done,
    output logic              sync_error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);

    rx_pixel_state_t state, state_next;

    logic byte_hs;
    logic hi_accept;
    logic lo_accept;
    logic timed_out;
    logic pixel_fire;
    logic tmo_clear;
    logic tmo_expired;

    always_ff @(posedge clk) begin
        if (!reset) state <= WAIT_HI;
        else        state <= state_next;
    end

    // NOTE: defaults first so every path assigns every output; no latches.
    always_comb begin
        state_next  = state;
        byte_ready  = 1'b0;
        pixel_valid = 1'b0;
        case (state)
            WAIT_HI: begin
                byte_ready = reset;
                if (byte_valid && reset) state_next = WAIT_LO;
            end
            WAIT_LO: begin
                byte_ready = reset;
                if (byte_valid && reset) state_next = PRESENT;
                else if (tmo_expired)    state_next = WAIT_HI;
            end
            PRESENT: begin
                pixel_valid = 1'b1;
                if (pixel_ready) state_next = WAIT_HI;
            end
            default: state_next = WAIT_HI;
        endcase
        if (frame_clear) state_next = WAIT_HI;
    end

    // frame_clear suppresses every handshake and event in its cycle.
    assign byte_hs    = byte_valid && byte_ready && !frame_clear;
    assign hi_accept  = byte_hs && (state == WAIT_HI);
    assign lo_accept  = byte_hs && (state == WAIT_LO);
    assign timed_out  = (state == WAIT_LO) && !(byte_valid && byte_ready)
                        && tmo_expired && !frame_clear;
    assign pixel_fire = pixel_valid && pixel_ready && !frame_clear;
    assign tmo_clear  = frame_clear || lo_accept || timed_out;

    byte_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_lo_watchdog (
        .clk    (clk),
        .reset  (reset),
        .start  (hi_accept),
        .clear  (tmo_clear),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pixel_out  <= '0;
            pixel_addr <= '0;
            frame_done <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_error <= 1'b0;
            if (hi_accept) pixel_out[HI_BYTE_MSB:HI_BYTE_LSB] <= byte_in;
            if (lo_accept) begin
                pixel_out  <= join_pixel(pixel_out[HI_BYTE_MSB:HI_BYTE_LSB], byte_in);
                sync_error <= (byte_in[3:0] != 4'h0);
            end
            if (timed_out) sync_error <= 1'b1;
            if (frame_clear) begin
                pixel_addr <= '0;
            end else if (pixel_fire) begin
                if (pixel_addr == LAST_ADDR) begin
                    pixel_addr <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pixel_addr <= pixel_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_receive_pixel.sv
// Directed bench for receive_pixel: byte pairing, address wrap, back-pressure,
// inter-byte timeout (including its last-allowed cycle), pad error, clear and reset.
module tb_receive_pixel;

    localparam int IMAGE_SIZE   = 4;
    localparam int ADDR_W       = 2;
    localparam int TIMEOUT_CLKS = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_clear;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [11:0]       pixel_out;
    logic [ADDR_W-1:0] pixel_addr;
    logic              pixel_valid;
    logic              pixel_ready;
    logic              frame_done;
    logic              sync_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] stream_px [4] = '{12'h00F, 12'h00F, 12'hF00, 12'h00F};

    receive_pixel #(
        .IMAGE_SIZE  (IMAGE_SIZE),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_clear(frame_clear),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pixel_out  (pixel_out),
        .pixel_addr (pixel_addr),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .frame_done (frame_done),
        .sync_error (sync_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic handshake();
        pixel_ready = 1'b1;
        step();
        pixel_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        frame_clear = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        pixel_ready = 1'b0;

        // Reset values
        step();
        step();
        check("rst_byte_ready",  16'(byte_ready),  16'h0);
        check("rst_pixel_valid", 16'(pixel_valid), 16'h0);
        check("rst_pixel_out",   16'(pixel_out),   16'h000);
        check("rst_pixel_addr",  16'(pixel_addr),  16'h0);
        check("rst_frame_done",  16'(frame_done),  16'h0);
        check("rst_sync_error",  16'(sync_error),  16'h0);
        reset = 1'b1;
        step();
        check("post_rst_byte_ready", 16'(byte_ready), 16'h1);

        // Basic pair F0, A0 -> F0A at address 0
        send_byte(8'hF0);
        check("t1_valid_after_hi", 16'(pixel_valid), 16'h0);
        check("t1_ready_after_hi", 16'(byte_ready),  16'h1);
        send_byte(8'hA0);
        check("t1_valid",      16'(pixel_valid), 16'h1);
        check("t1_pixel",      16'(pixel_out),   16'hF0A);
        check("t1_addr",       16'(pixel_addr),  16'h0);
        check("t1_sync_error", 16'(sync_error),  16'h0);
        check("t1_ready_pres", 16'(byte_ready),  16'h0);
        handshake();
        check("t1_hs_addr",  16'(pixel_addr),  16'h1);
        check("t1_hs_valid", 16'(pixel_valid), 16'h0);
        check("t1_hs_done",  16'(frame_done),  16'h0);

        // frame_clear while idle puts the address back to 0
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        check("clr_idle_addr",  16'(pixel_addr), 16'h0);
        check("clr_idle_ready", 16'(byte_ready), 16'h1);

        // Full frame with pixel_ready held high
        pixel_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(stream_px[i][11:4]);
            check("frm_done_idle", 16'(frame_done), 16'h0);
            send_byte({stream_px[i][3:0], 4'h0});
            check("frm_valid", 16'(pixel_valid), 16'h1);
            check("frm_pixel", 16'(pixel_out),   16'(stream_px[i]));
            check("frm_addr",  16'(pixel_addr),  16'(i));
            step();
            check("frm_done",    16'(frame_done), (i == 3) ? 16'h1 : 16'h0);
            check("frm_addr_hs", 16'(pixel_addr), 16'((i + 1) % 4));
        end
        send_byte(8'hAB);
        check("frm_done_one_cycle", 16'(frame_done), 16'h0);
        send_byte(8'hC0);
        check("wrap_pixel", 16'(pixel_out),  16'hABC);
        check("wrap_addr",  16'(pixel_addr), 16'h0);
        step();
        pixel_ready = 1'b0;
        check("wrap_hs_addr", 16'(pixel_addr), 16'h1);

        // Downstream stall with a byte waiting
        send_byte(8'h12);
        send_byte(8'h30);
        check("stall_pixel0", 16'(pixel_out), 16'h123);
        byte_in    = 8'h5F;
        byte_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("stall_byte_ready", 16'(byte_ready),  16'h0);
            check("stall_valid",      16'(pixel_valid), 16'h1);
            check("stall_pixel",      16'(pixel_out),   16'h123);
            check("stall_addr",       16'(pixel_addr),  16'h1);
        end
        pixel_ready = 1'b1;
        step();
        pixel_ready = 1'b0;
        check("stall_rel_valid", 16'(pixel_valid), 16'h0);
        check("stall_rel_ready", 16'(byte_ready),  16'h1);
        check("stall_rel_addr",  16'(pixel_addr),  16'h2);
        step();
        byte_valid = 1'b0;
        check("stall_hi_taken_ready", 16'(byte_ready),  16'h1);
        check("stall_hi_taken_valid", 16'(pixel_valid), 16'h0);
        send_byte(8'h60);
        check("stall_next_pixel", 16'(pixel_out),  16'h5F6);
        check("stall_next_addr",  16'(pixel_addr), 16'h2);
        handshake();
        check("stall_next_hs_addr", 16'(pixel_addr), 16'h3);

        // Timeout: high byte then silence
        send_byte(8'h12);
        for (int i = 0; i < TIMEOUT_CLKS - 1; i++) begin
            step();
            check("tmo_wait_sync",  16'(sync_error),  16'h0);
            check("tmo_wait_valid", 16'(pixel_valid), 16'h0);
        end
        step();
        check("tmo_sync_error", 16'(sync_error),  16'h1);
        check("tmo_no_valid",   16'(pixel_valid), 16'h0);
        check("tmo_ready",      16'(byte_ready),  16'h1);
        step();
        check("tmo_sync_one_cycle", 16'(sync_error), 16'h0);
        send_byte(8'h5F);
        send_byte(8'h10);
        check("tmo_resync_pixel", 16'(pixel_out),   16'h5F1);
        check("tmo_resync_valid", 16'(pixel_valid), 16'h1);
        check("tmo_resync_addr",  16'(pixel_addr),  16'h3);
        check("tmo_resync_sync",  16'(sync_error),  16'h0);
        handshake();
        check("tmo_frame_done", 16'(frame_done), 16'h1);
        check("tmo_addr_wrap",  16'(pixel_addr), 16'h0);
        step();
        check("tmo_done_one_cycle", 16'(frame_done), 16'h0);

        // Low byte on the last allowed cycle beats the timeout
        send_byte(8'h3C);
        repeat (TIMEOUT_CLKS - 1) step();
        send_byte(8'h70);
        check("edge_pixel", 16'(pixel_out),   16'h3C7);
        check("edge_valid", 16'(pixel_valid), 16'h1);
        check("edge_sync",  16'(sync_error),  16'h0);
        check("edge_addr",  16'(pixel_addr),  16'h0);
        handshake();
        check("edge_hs_addr", 16'(pixel_addr), 16'h1);

        // Nonzero pad nibble
        send_byte(8'hF0);
        send_byte(8'hA3);
        check("pad_sync_error", 16'(sync_error),  16'h1);
        check("pad_pixel",      16'(pixel_out),   16'hF0A);
        check("pad_valid",      16'(pixel_valid), 16'h1);
        check("pad_addr",       16'(pixel_addr),  16'h1);
        handshake();
        check("pad_sync_cleared", 16'(sync_error), 16'h0);
        check("pad_hs_addr",      16'(pixel_addr), 16'h2);

        // frame_clear in WAIT_LO with a competing byte
        send_byte(8'h77);
        frame_clear = 1'b1;
        byte_in     = 8'h80;
        byte_valid  = 1'b1;
        step();
        frame_clear = 1'b0;
        byte_valid  = 1'b0;
        check("clr_addr",  16'(pixel_addr),  16'h0);
        check("clr_ready", 16'(byte_ready),  16'h1);
        check("clr_valid", 16'(pixel_valid), 16'h0);
        check("clr_sync",  16'(sync_error),  16'h0);
        check("clr_done",  16'(frame_done),  16'h0);
        send_byte(8'h45);
        send_byte(8'h60);
        check("clr_next_pixel", 16'(pixel_out),   16'h456);
        check("clr_next_addr",  16'(pixel_addr),  16'h0);
        check("clr_next_valid", 16'(pixel_valid), 16'h1);

        // Reset while presenting
        reset = 1'b0;
        step();
        check("mid_rst_byte_ready",  16'(byte_ready),  16'h0);
        check("mid_rst_pixel_valid", 16'(pixel_valid), 16'h0);
        check("mid_rst_pixel_out",   16'(pixel_out),   16'h000);
        check("mid_rst_pixel_addr",  16'(pixel_addr),  16'h0);
        check("mid_rst_frame_done",  16'(frame_done),  16'h0);
        check("mid_rst_sync_error",  16'(sync_error),  16'h0);
        reset = 1'b1;
        step();
        check("mid_rst_release_ready", 16'(byte_ready), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/receive_pixel.md
# receive_pixel

Receive-side counterpart of the FPGA-to-NANO pixel link. It takes the byte stream from `uart_rx` and reassembles each pair of bytes into one 12-bit pixel. Byte order is high byte `pixel[11:4]` first, then low byte `{pixel[3:0],4'b0000}`. Each pixel is presented with its frame address on a valid/ready port for a frame buffer writer. An inter-byte timeout recovers byte alignment after a dropped byte.

## Interface
Parameters:
- `IMAGE_SIZE`, 4: pixels per frame; address wraps after `IMAGE_SIZE-1`.
- `ADDR_W`, `$clog2(IMAGE_SIZE)` (min 1): width of `pixel_addr`.
- `TIMEOUT_CLKS`, 13020: maximum clocks allowed between the high-byte accept and the low-byte accept (about 3 UART byte times at 115200 baud / 50 MHz).

Ports:
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-low.
- `frame_clear` input 1: synchronous pulse; discards any partial pixel and sets the address to 0.
- `byte_in` input 8: received byte from `uart_rx`.
- `byte_valid` input 1: `byte_in` is valid.
- `byte_ready` output 1: block can accept a byte.
- `pixel_out` output 12: reassembled pixel.
- `pixel_addr` output ADDR_W: frame address of `pixel_out`.
- `pixel_valid` output 1: `pixel_out`/`pixel_addr` are valid.
- `pixel_ready` input 1: downstream accepts the pixel.
- `frame_done` output 1: one-cycle pulse when the last pixel of a frame is handed off.
- `sync_error` output 1: one-cycle pulse on a timeout or a nonzero low-nibble pad.

## Operation
- States: `WAIT_HI`, `WAIT_LO`, `PRESENT`.
- Byte handshake: a byte is accepted on a rising edge with `byte_valid && byte_ready`.
- `byte_ready` = 1 in `WAIT_HI` and `WAIT_LO`, 0 in `PRESENT`, and 0 while `reset` = 0.
- `WAIT_HI`: on accept, capture `byte_in` into `pixel_out[11:4]`, then go to `WAIT_LO`.
- `WAIT_LO`: on accept, capture `byte_in[7:4]` into `pixel_out[3:0]`, then go to `PRESENT`.
  - If `byte_in[3:0]` != 0, pulse `sync_error`; the pixel is still delivered.
- `WAIT_LO` timeout: the counter starts at 0 on entry and increments every cycle without an accept. When it reaches `TIMEOUT_CLKS-1` with no accept:
  - pulse `sync_error`;
  - go to `WAIT_HI`;
  - discard the high byte (nothing is emitted).
- `PRESENT`: `pixel_valid` = 1 and `pixel_out`/`pixel_addr` are held stable until `pixel_ready`. On the handshake:
  - `pixel_addr` increments;
  - at `IMAGE_SIZE-1` it wraps to 0 and `frame_done` pulses;
  - the state goes to `WAIT_HI`.
- `frame_clear` (priority below `reset`, above everything else), next cycle:
  - state = `WAIT_HI`, `pixel_addr` = 0, timeout counter = 0;
  - `pixel_valid` = 0, with no `frame_done` and no `sync_error`;
  - a byte or pixel handshake in the same cycle is ignored.
- A timeout and a low-byte accept in the same cycle: the accept wins and there is no error.

## Timing
- Reset values: `byte_ready` 0, `pixel_valid` 0, `pixel_out` 0, `pixel_addr` 0, `frame_done` 0, `sync_error` 0. The state is `WAIT_HI`, so `byte_ready` = 1 in the first cycle after reset releases.
- Latency: `pixel_valid` rises in the cycle after the low-byte accept edge.
- Minimum spacing: 3 cycles per pixel (hi accept, lo accept, pixel handshake).
- `frame_done` and `sync_error` are registered. Each is high for exactly one cycle, in the cycle after its causing edge.
- Reset asserted mid-pixel: everything returns to reset values at the next edge and the partial pixel is lost.
- Downstream may stall indefinitely in `PRESENT`. Back-pressure reaches `uart_rx` only through `byte_ready`.

## Structure
- Shared package `pixel_link_pkg`:
  - constants `PIXEL_W`=12, `BYTE_W`=8, `HI_BYTE_MSB`=11, `HI_BYTE_LSB`=4;
  - the state enum `rx_pixel_state_t`;
  - a pure function `join_pixel(hi, lo)`, also usable by the send side for the inverse split.
- One sub-module, `byte_timeout`: a counter with `start`, `clear` and `expired` (parameter `TIMEOUT_CLKS`), instantiated for the `WAIT_LO` watchdog.

## Test plan
- Reset, then bytes `0xF0`, `0xA0` → `pixel_out`=`0xF0A`, `pixel_addr`=0, `pixel_valid` rises one cycle after the second accept; no `sync_error`.
- `IMAGE_SIZE`=4; stream pixels `0x00F`, `0x00F`, `0xF00`, `0x00F` with `pixel_ready` always 1 → addresses 0,1,2,3 in order; `frame_done` pulses once, after address 3; the next pixel is at address 0.
- Hold `pixel_ready`=0 for 50 cycles after a pixel, with `byte_valid`=1 offering `0x5F` → `byte_ready`=0, `pixel_out` held and the byte not consumed; release → handshake, then `0x5F` is accepted as the next high byte.
- Send high byte `0x12`, then no byte for `TIMEOUT_CLKS` cycles → `sync_error` pulse, no `pixel_valid`; then `0x5F`, `0x10` → `pixel_out`=`0x5F1`.
- Low byte `0xA3` after high byte `0xF0` → `sync_error` pulse and `pixel_out`=`0xF0A` delivered.
- `frame_clear` at `pixel_addr`=2 while in `WAIT_LO` → next cycle `pixel_addr`=0, `byte_ready`=1, no `pixel_valid`; `reset`=0 in `PRESENT` → all outputs at reset values the next cycle.
